// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requester logic and the shared 2-to-4 decoder arbiter.
// The arbiter side uses the slave modport; the requester side drives through master.
interface decoder_rr_arbiter_if;
    logic       enable;
    logic [3:0] req;
    logic [3:0] sel_n;
    logic [1:0] grant_idx;
    logic       dec_en_n;
    logic       busy;
    logic       timeout;

    modport master (
        output enable,
        output req,
        input  sel_n,
        input  grant_idx,
        input  dec_en_n,
        input  busy,
        input  timeout
    );

    modport slave (
        input  enable,
        input  req,
        output sel_n,
        output grant_idx,
        output dec_en_n,
        output busy,
        output timeout
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one active-low 2-to-4 decoder among four requesters,
// with a hold-time limit under contention and one dead cycle between grants.
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_rr_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       grant_idx_reg, grant_idx_next;
    logic [1:0]       last_reg, last_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [3:0]       sel_n_reg;
    logic             dec_en_n_reg;
    logic             busy_reg;
    logic             timeout_reg, timeout_next;

    logic [3:0]       rot_req;
    logic [3:0]       grant_oh;
    logic [3:0]       next_oh;
    logic [1:0]       offset;
    logic [1:0]       winner;
    logic             any_req;
    logic             others_req;
    logic             at_limit;

    // rot_req[k] is the request of the requester k+1 places after the last grantee.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_decode
            assign rot_req[gi]  = bus.req[2'(last_reg + 2'(gi) + 2'd1)];
            assign grant_oh[gi] = (grant_idx_reg == 2'(gi));
            assign next_oh[gi]  = (grant_idx_next == 2'(gi));
        end
    endgenerate

    always_comb begin
        offset = 2'd0;
        if (rot_req[0])      offset = 2'd0;
        else if (rot_req[1]) offset = 2'd1;
        else if (rot_req[2]) offset = 2'd2;
        else if (rot_req[3]) offset = 2'd3;
    end

    assign winner     = last_reg + offset + 2'd1;
    assign any_req    = |bus.req;
    assign others_req = |(bus.req & ~grant_oh);
    assign at_limit   = (hold_cnt_reg == CNT_W'(MAX_HOLD));

    always_comb begin
        state_next     = state_reg;
        grant_idx_next = grant_idx_reg;
        last_next      = last_reg;
        hold_cnt_next  = hold_cnt_reg;
        timeout_next   = 1'b0;
        case (state_reg)
            IDLE, GAP: begin
                if (bus.enable && any_req) begin
                    state_next     = GRANT;
                    grant_idx_next = winner;
                    hold_cnt_next  = CNT_W'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                if (!bus.enable || !bus.req[grant_idx_reg]) begin
                    state_next = GAP;
                    last_next  = grant_idx_reg;
                end else if (at_limit && others_req) begin
                    state_next   = GAP;
                    last_next    = grant_idx_reg;
                    timeout_next = 1'b1;
                end else if (!at_limit) begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so nothing is combinational from req/enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grant_idx_reg <= 2'd0;
            last_reg      <= 2'd3;
            hold_cnt_reg  <= '0;
            sel_n_reg     <= 4'b1111;
            dec_en_n_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_idx_reg <= grant_idx_next;
            last_reg      <= last_next;
            hold_cnt_reg  <= hold_cnt_next;
            sel_n_reg     <= (state_next == GRANT) ? ~next_oh : 4'b1111;
            dec_en_n_reg  <= (state_next != GRANT);
            busy_reg      <= (state_next != IDLE);
            timeout_reg   <= timeout_next;
        end
    end

    assign bus.sel_n     = sel_n_reg;
    assign bus.grant_idx = grant_idx_reg;
    assign bus.dec_en_n  = dec_en_n_reg;
    assign bus.busy      = busy_reg;
    assign bus.timeout   = timeout_reg;

endmodule
